execute_cycle: RTL and testbench

- RV32I pipeline Execute stage.
- Consumes decoded operands and controls from the Decode→Execute register, applies forwarding, computes the ALU result, resolves branches and jumps, and registers everything into the Execute→Memory pipeline register feeding the memory stage.
- Redirect outputs (PCSrcE, PCTargetE) go back to the fetch stage.

---
 rtl/execute_cycle.sv | 203 ++++++++++++++++++++
 tb/tb_execute_cycle.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// execute_cycle: RV32I Execute stage with forwarding, ALU, branch resolution and EX->MEM register.
// Optional iterative multiplier enabled by defining EX_MUL_EN.
`default_nettype none

module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            LoadE,
    input  logic            StoreE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] InstrE,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            BusyE,
    output logic            RegWriteM,
    output logic            LoadM,
    output logic            StoreM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM,
    output logic [XLEN-1:0] InstrM
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_AUI  = 4'b1011;
    localparam logic [3:0] ALU_MUL  = 4'b1100;

    logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_result, jalr_sum;
    logic [4:0]      shamt;
    logic            taken, busy;

    always_comb begin
        case (ForwardA_E)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALU_ResultM;
            default: fwd_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_a = fwd_a;
    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
    assign shamt = src_b[4:0];

`ifdef EX_MUL_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
    logic            is_mul;

    assign is_mul = (ALUControlE == ALU_MUL);
    assign busy   = ((state_q == ST_IDLE) && is_mul) || (state_q == ST_RUN);

    // Shift-add: multiplicand moves left, multiplier right, one bit per RUN cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (is_mul) begin
                    state_d = ST_RUN;
                    cnt_d   = 5'd0;
                    mul_a_d = src_a;
                    mul_b_d = src_b;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                acc_d   = acc_q + (mul_b_q[0] ? mul_a_q : '0);
                mul_a_d = mul_a_q << 1;
                mul_b_d = mul_b_q >> 1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            acc_q   <= acc_d;
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        case (ALUControlE)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_LUI:  alu_result = src_b;
            ALU_AUI:  alu_result = PCE + src_b;
`ifdef EX_MUL_EN
            ALU_MUL:  alu_result = acc_q;
`endif
            default:  alu_result = '0;
        endcase
    end

    always_comb begin
        case (InstrE[14:12])
            3'b000:  taken = (fwd_a == fwd_b);
            3'b001:  taken = (fwd_a != fwd_b);
            3'b100:  taken = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  taken = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  taken = (fwd_a <  fwd_b);
            3'b111:  taken = (fwd_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum  = src_a + Imm_Ext_E;
    assign PCTargetE = (InstrE[6:0] == 7'b1100111) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                   : PCE + Imm_Ext_E;
    assign PCSrcE    = ((BranchE & taken) | JumpE) & ~busy;
    assign BusyE     = busy;

    // While the multiplier is busy the M register takes a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            LoadM       <= 1'b0;
            StoreM      <= 1'b0;
            ResultSrcM  <= 2'b0;
            RD_M        <= 5'd0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
            InstrM      <= '0;
        end else begin
            RegWriteM   <= RegWriteE & ~busy;
            LoadM       <= LoadE & ~busy;
            StoreM      <= StoreE & ~busy;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwd_b;
            ALU_ResultM <= alu_result;
            InstrM      <= InstrE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed self-checking bench for execute_cycle.
`default_nettype none

module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, LoadE, StoreE, BranchE, JumpE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, InstrE;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [31:0] ResultW;
    logic        PCSrcE, BusyE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, LoadM, StoreM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM, InstrM;

    int n_checks = 0;
    int n_fail   = 0;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .LoadE(LoadE), .StoreE(StoreE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .InstrE(InstrE), .RD_E(RD_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .LoadM(LoadM), .StoreM(StoreM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .InstrM(InstrM)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; LoadE = 0; StoreE = 0; BranchE = 0; JumpE = 0; ALUSrcE = 0;
        ResultSrcE = 2'b00; ALUControlE = 4'b0000;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; InstrE = 0;
        RD_E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
    endtask

    task automatic alu_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        clear_inputs();
        ALUControlE = ctl; RD1_E = a; RD2_E = b;
    endtask

    initial begin
        int edges;
        int bubble_bad;

        clear_inputs();
        rst = 1'b0;
        #12;
        check_eq("reset_alu", ALU_ResultM, 32'h0);
        check_eq("reset_regwrite", {31'b0, RegWriteM}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ADD with forwarding from ALU_ResultM
        alu_op(4'b0000, 32'h10, 32'h0);
        tick();
        check_eq("add_seed", ALU_ResultM, 32'h10);
        alu_op(4'b0000, 32'h5, 32'h0);
        ForwardA_E = 2'b10; ALUSrcE = 1; Imm_Ext_E = 32'h3;
        tick();
        check_eq("add_fwd_m", ALU_ResultM, 32'h13);

        // ForwardA=11 behaves as 00
        alu_op(4'b0001, 32'h100, 32'h1);
        ForwardA_E = 2'b11; ResultW = 32'hFFFF;
        tick();
        check_eq("sub_fwd11", ALU_ResultM, 32'hFF);

        alu_op(4'b1000, 32'hFFFFFFFF, 32'h1);
        tick();
        check_eq("slt", ALU_ResultM, 32'h1);
        alu_op(4'b1001, 32'hFFFFFFFF, 32'h1);
        tick();
        check_eq("sltu", ALU_ResultM, 32'h0);
        alu_op(4'b0111, 32'h80000000, 32'h4);
        tick();
        check_eq("sra", ALU_ResultM, 32'hF8000000);
        alu_op(4'b0110, 32'h80000000, 32'h24);
        tick();
        check_eq("srl_shamt5", ALU_ResultM, 32'h08000000);
        alu_op(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00);
        tick();
        check_eq("xor", ALU_ResultM, 32'h0FF00FF0);
        alu_op(4'b1011, 32'h0, 32'h0);
        PCE = 32'h1000; ALUSrcE = 1; Imm_Ext_E = 32'h5000;
        tick();
        check_eq("auipc", ALU_ResultM, 32'h6000);
        alu_op(4'b1110, 32'h3, 32'h4);
        tick();
        check_eq("undef_op", ALU_ResultM, 32'h0);

        // Store with WriteData forwarded from ResultW, plus passthrough fields
        alu_op(4'b0000, 32'h200, 32'h1111);
        StoreE = 1; ALUSrcE = 1; Imm_Ext_E = 32'h8; ForwardB_E = 2'b01; ResultW = 32'hDEADBEEF;
        RD_E = 5'd7; ResultSrcE = 2'b10; PCPlus4E = 32'h44; InstrE = 32'h00A12023;
        tick();
        check_eq("store_data", WriteDataM, 32'hDEADBEEF);
        check_eq("store_flag", {31'b0, StoreM}, 32'h1);
        check_eq("store_addr", ALU_ResultM, 32'h208);
        check_eq("rd_m", {27'b0, RD_M}, 32'h7);
        check_eq("resultsrc_m", {30'b0, ResultSrcM}, 32'h2);
        check_eq("pcplus4_m", PCPlus4M, 32'h44);
        check_eq("instr_m", InstrM, 32'h00A12023);

        // BLT taken, BGE not taken
        alu_op(4'b0001, 32'hFFFFFFFE, 32'h1);
        BranchE = 1; PCE = 32'h100; Imm_Ext_E = 32'h20; InstrE = {17'b0, 3'b100, 5'b0, 7'b1100011};
        #1;
        check_eq("blt_taken", {31'b0, PCSrcE}, 32'h1);
        check_eq("blt_target", PCTargetE, 32'h120);
        InstrE = {17'b0, 3'b101, 5'b0, 7'b1100011};
        #1;
        check_eq("bge_not_taken", {31'b0, PCSrcE}, 32'h0);
        BranchE = 0;

        // JALR clears bit 0
        alu_op(4'b0000, 32'h203, 32'h0);
        JumpE = 1; ALUSrcE = 1; Imm_Ext_E = 32'h0; PCE = 32'h500; InstrE = 32'h000000E7;
        #1;
        check_eq("jalr_target", PCTargetE, 32'h202);
        check_eq("jalr_pcsrc", {31'b0, PCSrcE}, 32'h1);

        // Asynchronous reset mid-stream
        alu_op(4'b0011, 32'h00F0, 32'h0F00);
        RegWriteE = 1; RD_E = 5'd3;
        tick();
        check_eq("or_before_rst", ALU_ResultM, 32'h0FF0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_alu", ALU_ResultM, 32'h0);
        check_eq("async_rst_rd", {27'b0, RD_M}, 32'h0);
        check_eq("async_rst_rw", {31'b0, RegWriteM}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("post_rst_alu", ALU_ResultM, 32'h0FF0);
        check_eq("post_rst_rw", {31'b0, RegWriteM}, 32'h1);

`ifdef EX_MUL_EN
        alu_op(4'b1100, 32'h12345678, 32'h3);
        RegWriteE = 1; JumpE = 1; RD_E = 5'd9;
        #1;
        check_eq("mul_busy_issue", {31'b0, BusyE}, 32'h1);
        edges = 0;
        bubble_bad = 0;
        while (BusyE && edges < 40) begin
            if (PCSrcE !== 1'b0) bubble_bad++;
            tick();
            edges++;
            if (RegWriteM !== 1'b0) bubble_bad++;
        end
        check_eq("mul_busy_cycles", edges, 33);
        check_eq("mul_bubbles", bubble_bad, 0);
        tick();
        check_eq("mul_result", ALU_ResultM, 32'h369D0368);
        check_eq("mul_regwrite", {31'b0, RegWriteM}, 32'h1);

        // Reset during RUN at count 10
        alu_op(4'b1100, 32'h7, 32'h9);
        repeat (11) tick();
        check_eq("mul_busy_run", {31'b0, BusyE}, 32'h1);
        ALUControlE = 4'b0000;
        rst = 1'b0;
        #1;
        check_eq("mul_rst_busy", {31'b0, BusyE}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("mul_rst_add", ALU_ResultM, 32'h10);
`else
        alu_op(4'b1100, 32'h12345678, 32'h3);
        RegWriteE = 1;
        #1;
        check_eq("mul_off_busy", {31'b0, BusyE}, 32'h0);
        tick();
        check_eq("mul_off_result", ALU_ResultM, 32'h0);
        check_eq("mul_off_regwrite", {31'b0, RegWriteM}, 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
